instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//  Prefetch buffer between the instruction fetch unit and decode.
//  Holds up to DEPTH fetched {PC, instruction} pairs in a circular FIFO.
//  Fetch can run ahead while decode stalls.
//  Flush discards all buffered entries on a taken branch, jump or jr.
// PARAMETERS
//  DEPTH    4   number of entries; power of two, >= 2
//  ADDR_W   2   log2(DEPTH); pointer width
//  DATA_W   32  instruction width and PC width
// PORTS
//  Clk        in   1         rising-edge clock; the block's single clock
//  Reset      in   1         asynchronous, active-low; queue empty while low
//  Flush      in   1         sync; drops all entries and any same-cycle push
//  In_valid   in   1         fetch presents a valid {In_pc, In_instr}
//  In_ready   out  1         queue can accept a push this cycle
//  In_pc      in   DATA_W    PC of the incoming instruction
//  In_instr   in   DATA_W    incoming instruction word
//  Out_valid  out  1         head entry valid
//  Out_ready  in   1         decode consumes the head this cycle
//  Out_pc     out  DATA_W    head PC; 0 when Out_valid=0
//  Out_instr  out  DATA_W    head instruction; 0 when Out_valid=0
//  Count      out  ADDR_W+1  current occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset low: wr_ptr=rd_ptr=0, Count=0, Out_valid=0, Out_pc=Out_instr=0.
//    In_ready=1 once Reset is released.
//  - push = In_valid & In_ready & ~Flush.
//  - pop = Out_valid & Out_ready & ~Flush.
//  - In_ready = (Count != DEPTH). No combinational path from Out_ready.
//  - Out_valid = (Count != 0). Out_* are driven from storage[rd_ptr], masked to 0 when empty.
//  - Latency: an entry pushed at edge N is visible on Out_* after edge N. No fall-through.
//  - Push writes storage[wr_ptr] and increments wr_ptr mod DEPTH.
//  - Pop increments rd_ptr mod DEPTH.
//  - Count update: +1 on push only, -1 on pop only, unchanged on push and pop together.
//  - Full (Count=DEPTH): In_ready=0. A pop that cycle frees a slot; In_ready rises the next cycle.
//  - Empty: Out_valid=0. Out_ready is ignored; Count never underflows.
//  - Flush priority: Flush > pop > push. On the edge with Flush=1, wr_ptr=rd_ptr=0 and Count=0.
//    Same-cycle push and pop are suppressed. Out_valid=0 on the next cycle.
//  - Pointer wrap: pointers are ADDR_W bits and wrap naturally. Full/empty come from Count only.
//  - Reset asserted mid-operation clears the queue immediately (asynchronous).
//    Storage contents need no reset.
//  - No state machine beyond the pointers and Count; all outputs are deterministic when empty.
// STRUCTURE
//  - Shared package holds: DATA_W=32, DEPTH default, and the boot PC constant 32'h0000_3000.
//    The fetch unit and the bench both use the boot PC.
//  - Single module, no sub-module.
//  - Storage is two DATA_W x DEPTH register arrays (pc, instr), or one 2*DATA_W array.
//  - Pointers and Count live in one always block with async active-low reset.
// TESTING
//  1. Reset low 3 cycles, then high.
//     -> Count=0, Out_valid=0, Out_pc=0, In_ready=1.
//  2. Push PCs 0x3000,0x3004,0x3008,0x300C with Out_ready=0.
//     -> Count=4, In_ready=0. A 5th push (0x3010) is refused and Count stays 4.
//  3. From full, hold Out_ready=1 with In_valid=0.
//     -> Out_pc sequence 0x3000,0x3004,0x3008,0x300C, then Out_valid=0 and Count=0.
//  4. Steady stream: push and pop every cycle for 10 cycles.
//     -> Count constant, ordering preserved, pointers wrap through 0 at least twice.
//  5. Hold 3 entries, then assert Flush with In_valid=1 (PC 0x3040) and Out_ready=1.
//     -> next cycle Count=0, Out_valid=0, and 0x3040 never emerges.
//  6. Drop Reset low mid-stream with Count=2.
//     -> Out_valid falls immediately (before the next edge) and Count=0.

Source files
------------

// File: rtl/instr_fetch_queue_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_fetch_queue_pkg                                              |
// | Shared fetch-path constants: word width, queue depth, boot PC.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package instr_fetch_queue_pkg;
  localparam int XLEN          = 32;
  localparam int DEFAULT_DEPTH = 4;
  localparam logic [XLEN-1:0] C_BOOT_PC = 32'h0000_3000;
endpackage
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_fetch_queue                                                  |
// | Circular {PC, instr} prefetch FIFO between fetch and decode.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = XLEN
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [DATA_W-1:0] In_pc,
  input  logic [DATA_W-1:0] In_instr,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic [DATA_W-1:0] Out_pc,
  output logic [DATA_W-1:0] Out_instr,
  output logic [ADDR_W:0]   Count
);

  localparam logic [ADDR_W:0] c_full = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_pc_mem    [DEPTH];
  logic [DATA_W-1:0] r_instr_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_push;
  logic              w_pop;

  // Handshakes depend only on occupancy, never on the opposite side's ready.
  assign In_ready  = (r_count != c_full);
  assign Out_valid = (r_count != '0);
  assign Count     = r_count;
  assign w_push    = In_valid & In_ready & ~Flush;
  assign w_pop     = Out_valid & Out_ready & ~Flush;

  assign Out_pc    = Out_valid ? r_pc_mem[r_rd_ptr]    : '0;
  assign Out_instr = Out_valid ? r_instr_mem[r_rd_ptr] : '0;

  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= In_pc;
      r_instr_mem[r_wr_ptr] <= In_instr;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (Flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_instr_fetch_queue                                               |
// | Directed plus random checks of the prefetch queue vs a queue model.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_instr_fetch_queue;
  import instr_fetch_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Reset, Flush, In_valid, Out_ready;
  logic        In_ready, Out_valid;
  logic [31:0] In_pc, In_instr, Out_pc, Out_instr;
  logic [2:0]  Count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  instr_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(2), .DATA_W(32)) dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush),
    .In_valid(In_valid), .In_ready(In_ready), .In_pc(In_pc), .In_instr(In_instr),
    .Out_valid(Out_valid), .Out_ready(Out_ready), .Out_pc(Out_pc), .Out_instr(Out_instr),
    .Count(Count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs with the queue model.
  task automatic check_model();
    logic [31:0] epc, ein;
    epc = (q.size() != 0) ? q[0].pc    : 32'h0;
    ein = (q.size() != 0) ? q[0].instr : 32'h0;
    check("count",     64'(Count),     64'(q.size()));
    check("out_valid", 64'(Out_valid), 64'(q.size() != 0));
    check("in_ready",  64'(In_ready),  64'(q.size() != DEPTH));
    check("out_pc",    64'(Out_pc),    64'(epc));
    check("out_instr", 64'(Out_instr), 64'(ein));
  endtask

  // One clock: check outputs, advance the model by the queue's rules.
  task automatic cycle();
    bit   push, pop;
    ent_t e;
    #1;
    check_model();
    push = In_valid && (q.size() != DEPTH) && !Flush;
    pop  = (q.size() != 0) && Out_ready && !Flush;
    e.pc = In_pc;
    e.instr = In_instr;
    @(posedge Clk);
    if (Flush) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(e);
    end
    #1;
  endtask

  task automatic drive(input bit v, input bit r, input bit f, input logic [31:0] pc);
    In_valid  = v;
    Out_ready = r;
    Flush     = f;
    In_pc     = pc;
    In_instr  = $urandom;
  endtask

  initial begin
    Reset = 1'b0;
    drive(0, 0, 0, 32'h0);
    // Reset held low for three cycles
    repeat (3) @(posedge Clk);
    #1;
    check("rst_count",    64'(Count),     64'd0);
    check("rst_out_valid", 64'(Out_valid), 64'd0);
    check("rst_out_pc",   64'(Out_pc),    64'd0);
    Reset = 1'b1;
    #1;
    check("rst_in_ready", 64'(In_ready),  64'd1);

    // Fill to full, then attempt a fifth push
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, C_BOOT_PC + 32'(4 * i));
      cycle();
    end
    check("full_count", 64'(Count),    64'd4);
    check("full_ready", 64'(In_ready), 64'd0);
    drive(1, 0, 0, C_BOOT_PC + 32'h10);
    cycle();
    check("refused_count", 64'(Count), 64'd4);

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 32'h0);
      #1;
      check("drain_pc", 64'(Out_pc), 64'(C_BOOT_PC + 32'(4 * i)));
      cycle();
    end
    check("drained_valid", 64'(Out_valid), 64'd0);
    check("drained_count", 64'(Count),     64'd0);

    // Steady stream at occupancy 2
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, C_BOOT_PC + 32'h100 + 32'(4 * i));
      cycle();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, C_BOOT_PC + 32'h108 + 32'(4 * i));
      #1;
      check("stream_count", 64'(Count), 64'd2);
      check("stream_pc",    64'(Out_pc), 64'(C_BOOT_PC + 32'h100 + 32'(4 * i)));
      cycle();
    end

    // Random traffic with occasional flush
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 19) == 0), C_BOOT_PC + 32'($urandom_range(0, 1023) * 4));
      cycle();
    end

    // Flush with three entries and a same-cycle push/pop
    drive(0, 0, 1, 32'h0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, C_BOOT_PC + 32'h20 + 32'(4 * i));
      cycle();
    end
    check("pre_flush_count", 64'(Count), 64'd3);
    drive(1, 1, 1, C_BOOT_PC + 32'h40);
    cycle();
    check("flush_count", 64'(Count),     64'd0);
    check("flush_valid", 64'(Out_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 32'h0);
      #1;
      check("no_3040", 64'(Out_pc == (C_BOOT_PC + 32'h40)), 64'd0);
      cycle();
    end

    // Asynchronous reset mid-stream with two entries held
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, C_BOOT_PC + 32'h80 + 32'(4 * i));
      cycle();
    end
    check("pre_rst_count", 64'(Count), 64'd2);
    drive(0, 0, 0, 32'h0);
    Reset = 1'b0;
    #1;
    check("async_valid", 64'(Out_valid), 64'd0);
    check("async_count", 64'(Count),     64'd0);
    q.delete();
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 32'($urandom));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
